// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART transmit line between four byte requesters. In IDLE a
//   round-robin search (starting after the last winner) picks one pending
//   requester. Its byte is captured and acknowledged, then sent as an 8N1
//   frame (start, 8 data bits LSB first, stop), each bit CLKS_PER_BIT clocks.
//
// Ports
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset
//   en         : arbitration enable, sampled only in IDLE
//   req[3:0]   : per-requester byte-pending flags
//   req_data   : byte i at req_data[8*i+7:8*i]
//   ack[3:0]   : one-cycle one-hot capture pulse
//   tx         : serial output, idles high
//   busy       : frame in progress (START/DATA/STOP)
//   active_id  : owner of the current or most recent frame
//   frame_done : one-cycle pulse in the first IDLE cycle after a frame
module uart_tx_arbiter #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [3:0]  req,
  input  logic [31:0] req_data,
  output logic [3:0]  ack,
  output logic        tx,
  output logic        busy,
  output logic [1:0]  active_id,
  output logic        frame_done
);

  localparam int unsigned  BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        r_state, w_state_next;
  logic [BW-1:0] r_baud,  w_baud_next;
  logic [2:0]    r_bit,   w_bit_next;
  logic [7:0]    r_shift, w_shift_next;
  logic [1:0]    r_ptr,   w_ptr_next;
  logic          r_tx,    w_tx_next;
  logic [3:0]    r_ack,   w_ack_next;
  logic [1:0]    r_id,    w_id_next;
  logic          r_done,  w_done_next;

  logic          w_found;
  logic [1:0]    w_win;
  logic [1:0]    w_cand;
  logic          w_baud_wrap;

  // Search ptr+1, ptr+2, ptr+3, ptr (mod 4); first pending requester wins.
  always_comb begin : arbiter
    w_found = 1'b0;
    w_win   = r_ptr;
    w_cand  = r_ptr;
    for (int unsigned i = 1; i <= 4; i++) begin
      w_cand = r_ptr + 2'(i);
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  assign w_baud_wrap = (r_baud == BAUD_LAST);

  always_comb begin : next_state
    w_state_next = r_state;
    w_baud_next  = w_baud_wrap ? '0 : r_baud + 1'b1;
    w_bit_next   = r_bit;
    w_shift_next = r_shift;
    w_ptr_next   = r_ptr;
    w_tx_next    = r_tx;
    w_ack_next   = '0;
    w_id_next    = r_id;
    w_done_next  = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_tx_next   = 1'b1;
        w_baud_next = '0;
        if (en && w_found) begin
          w_ack_next   = 4'b0001 << w_win;
          w_id_next    = w_win;
          w_ptr_next   = w_win;
          w_shift_next = req_data[8*w_win +: 8];
          w_tx_next    = 1'b0;
          w_state_next = START;
        end
      end
      START: begin
        if (w_baud_wrap) begin
          w_tx_next    = r_shift[0];
          w_bit_next   = '0;
          w_state_next = DATA;
        end
      end
      DATA: begin
        if (w_baud_wrap) begin
          // r_bit wraps 7 -> 0 as the last data bit ends.
          w_bit_next = r_bit + 1'b1;
          if (r_bit == 3'd7) begin
            w_tx_next    = 1'b1;
            w_state_next = STOP;
          end else begin
            w_shift_next = r_shift >> 1;
            w_tx_next    = r_shift[1];
          end
        end
      end
      STOP: begin
        if (w_baud_wrap) begin
          w_state_next = IDLE;
          w_done_next  = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_ptr   <= 2'd3;
      r_tx    <= 1'b1;
      r_ack   <= '0;
      r_id    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_baud  <= w_baud_next;
      r_bit   <= w_bit_next;
      r_shift <= w_shift_next;
      r_ptr   <= w_ptr_next;
      r_tx    <= w_tx_next;
      r_ack   <= w_ack_next;
      r_id    <= w_id_next;
      r_done  <= w_done_next;
    end
  end

  assign ack        = r_ack;
  assign tx         = r_tx;
  assign busy       = (r_state != IDLE);
  assign active_id  = r_id;
  assign frame_done = r_done;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter. A transaction-level model tracks the
// position inside the current frame (cycles since ack) and derives every
// expected output from it; requesters are driven by directed phases and
// then by randomized traffic.
module tb_uart_tx_arbiter;

  localparam int unsigned C  = 4;
  localparam int          FL = 10 * C;

  logic        clk = 1'b0;
  logic        rst, en;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic        tx, busy, frame_done;
  logic [1:0]  active_id;

  uart_tx_arbiter #(.CLKS_PER_BIT(C)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .req_data(req_data),
    .ack(ack), .tx(tx), .busy(busy), .active_id(active_id),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // model: m_pos = cycles since ack within the frame, -1 when idle
  int          m_pos = -1;
  int unsigned m_ptr = 3;
  int unsigned m_id  = 0;
  logic [7:0]  m_byte = '0;
  logic        m_fd  = 1'b0;

  int unsigned policy;      // 0 hold req, 1 drop on ack, 2 random traffic
  logic        timing_chk, per_chk, have_prev, seen_on;
  int unsigned cyc = 0, prev_ack = 0;
  logic [9:0]  seen = '0;
  int unsigned grants[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_edge();
    logic found;
    int unsigned c;
    if (rst) begin
      m_pos = -1; m_fd = 1'b0; m_ptr = 3; m_id = 0;
    end else if (m_pos < 0) begin
      m_fd = 1'b0;
      if (en && req != 4'b0) begin
        found = 1'b0;
        for (int unsigned j = 1; j <= 4; j++) begin
          c = (m_ptr + j) % 4;
          if (!found && req[c]) begin
            found = 1'b1;
            m_id  = c;
          end
        end
        m_ptr  = m_id;
        m_byte = req_data[8*m_id +: 8];
        m_pos  = 0;
      end
    end else if (m_pos == FL - 1) begin
      m_pos = -1; m_fd = 1'b1;
    end else begin
      m_pos++; m_fd = 1'b0;
    end
  endtask

  function automatic logic exp_tx();
    int b;
    if (m_pos < 0) return 1'b1;
    b = m_pos / int'(C);
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return m_byte[b-1];
  endfunction

  task automatic step();
    model_edge();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    chk("ack",        {28'b0, ack},       (m_pos == 0) ? (32'd1 << m_id) : 32'd0);
    chk("busy",       {31'b0, busy},      {31'b0, m_pos >= 0});
    chk("tx",         {31'b0, tx},        {31'b0, exp_tx()});
    chk("active_id",  {30'b0, active_id}, m_id);
    chk("frame_done", {31'b0, frame_done}, {31'b0, m_fd});
    if (seen_on && m_pos >= 0 && (m_pos % int'(C)) == int'(C / 2))
      seen[m_pos / int'(C)] = tx;
    if (ack != 4'b0) begin
      for (int unsigned i = 0; i < 4; i++) if (ack[i]) grants.push_back(i);
      if (per_chk && have_prev) chk("frame_period", cyc - prev_ack, FL + 1);
      prev_ack  = cyc;
      have_prev = 1'b1;
    end
    // frame_done lands 10*C cycles after the ack cycle (the 41st cycle
    // of the transaction when the ack cycle is counted as the first)
    if (frame_done && timing_chk) chk("done_latency", cyc - prev_ack, FL);
    // requester reaction, driven from the model's view of the grant
    if (m_pos == 0 && policy == 1) req[m_id] = 1'b0;
    if (policy == 2) begin
      if (m_pos == 0) begin
        if ($urandom_range(1) == 1) req_data[8*m_id +: 8] = 8'($urandom);
        else                        req[m_id] = 1'b0;
      end
      for (int unsigned i = 0; i < 4; i++) begin
        if (!req[i]) begin
          req_data[8*i +: 8] = 8'($urandom);
          if ($urandom_range(15) == 0) req[i] = 1'b1;
        end
      end
      en  = ($urandom_range(7) != 0);
      rst = ($urandom_range(999) == 0);
    end
  endtask

  task automatic drain();
    req = '0;
    repeat (FL + 2) step();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; req = '0; req_data = '0;
    policy = 0; timing_chk = 0; per_chk = 0; have_prev = 0; seen_on = 0;
    step(); step();
    rst = 1'b0;
    step();

    // single byte 0xA5 from requester 0
    timing_chk = 1; policy = 1; en = 1'b1;
    req_data = 32'h0000_00A5; req = 4'b0001; seen_on = 1;
    repeat (FL + 5) step();
    seen_on = 0;
    chk("a5_bit_seq", {22'b0, seen}, 32'h34A);

    // fairness: all four requesting continuously after a reset
    rst = 1'b1; step(); rst = 1'b0;
    grants.delete(); have_prev = 0; per_chk = 1; policy = 0;
    req_data = 32'h4433_2211; req = 4'hF;
    repeat (4 * (FL + 1) + 3) step();
    drain();
    per_chk = 0;
    chk("fair_count", grants.size(), 5);
    for (int i = 0; i < 5 && i < grants.size(); i++)
      chk("fair_order", grants[i], (i == 4) ? 0 : i);

    // pointer rotation: grant 2, then req=1010 -> 3 then 1
    grants.delete(); policy = 1;
    req_data = 32'h9988_7766; req = 4'b0100;
    step();
    req = 4'b1010;
    repeat (3 * (FL + 1) + 2) step();
    drain();
    chk("rot_count", grants.size(), 3);
    if (grants.size() == 3) begin
      chk("rot_first",  grants[0], 2);
      chk("rot_second", grants[1], 3);
      chk("rot_third",  grants[2], 1);
    end

    // reset during data bit 3, then a normal grant
    timing_chk = 0;
    req_data = $urandom; req = 4'b0001;
    step();
    repeat (4 * C + 1) step();
    rst = 1'b1; step(); rst = 1'b0;
    repeat (FL + 2) step();
    grants.delete();
    req_data = $urandom; req = 4'b0001;
    step();
    chk("regrant_after_reset", grants.size(), 1);
    repeat (FL + 2) step();

    // enable gating and en dropped mid-frame
    en = 1'b0; req = 4'b0100; req_data = $urandom;
    grants.delete();
    repeat (50) step();
    chk("no_grant_when_disabled", grants.size(), 0);
    en = 1'b1;
    step();
    chk("grant_on_enable", grants.size(), 1);
    repeat (20) step();
    en = 1'b0;
    repeat (FL) step();
    en = 1'b1;

    // data and req changed mid-frame must not alter the frame
    req_data = $urandom; req = 4'b0010;
    step();
    repeat (10) step();
    req_data = $urandom;
    repeat (FL) step();

    // randomized traffic
    policy = 2;
    repeat (3000) step();
    policy = 0; rst = 1'b0; en = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
